// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 cipher core and its key expander:
// FSM state type, round constants and GF(2^8) helpers.
// The S-box is computed as GF(2^8) inversion followed by the affine map, which
// keeps the byte substitution logic free of large constant tables.
package aes_pkg;

  localparam int NR          = 10;  // AES-128 round count
  localparam int KFWD_CYCLES = 10;  // expander steps needed to reach rk10

  typedef enum logic [1:0] {
    S_IDLE,
    S_KFWD,
    S_ROUND,
    S_FIN
  } state_t;

  // Multiply by x modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product; used with constants 9/11/13/14 by InvMixColumns.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Round constant used to derive rk[i] from rk[i-1].
  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_cipher_core_if.sv
// Host-side bus of aes_cipher_core.
//   start/decrypt/din : operation request, sampled by the core only in IDLE
//   busy/done/dout    : status, one-cycle completion pulse, held result
interface aes_cipher_core_if;
  logic         start;
  logic         decrypt;
  logic [127:0] din;
  logic         busy;
  logic         done;
  logic [127:0] dout;

  modport master (output start, decrypt, din, input busy, done, dout);
  modport slave  (input start, decrypt, din, output busy, done, dout);
endinterface

// File: rtl/aes_round.sv
// Combinational AES round.
//   i_st    : state entering the round      i_rk    : round key
//   i_inv   : 1 = inverse cipher round      i_final : omit (Inv)MixColumns
//   o_st    : state leaving the round
// Forward:  MixColumns(ShiftRows(SubBytes(st))) ^ rk
// Inverse:  InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ rk)
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] i_st,
  input  logic [127:0] i_rk,
  input  logic         i_inv,
  input  logic         i_final,
  output logic [127:0] o_st
);
  logic [127:0] w_sb, w_isr, w_isb, w_sr, w_ark_inv;

  // Byte k = 4*column + row sits at bits [127-8k -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    int           src;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        src = inv ? (c + 4 - row) % 4 : (c + row) % 4;
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*src+row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    if (!inv)
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    return {gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9),
            gf_mul(a0, 8'd9)  ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13),
            gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11),
            gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9)  ^ gf_mul(a3, 8'd14)};
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = mix_col(s[127-32*c -: 32], inv);
    return r;
  endfunction

  assign w_isr = shift_rows(i_st, 1'b1);

  for (genvar c = 0; c < 4; c++) begin : g_col
    subword    u_sub  (.i_word(i_st[127-32*c -: 32]),  .o_word(w_sb[127-32*c -: 32]));
    invsubword u_isub (.i_word(w_isr[127-32*c -: 32]), .o_word(w_isb[127-32*c -: 32]));
  end

  assign w_sr      = shift_rows(w_sb, 1'b0);
  assign w_ark_inv = w_isb ^ i_rk;

  always_comb begin
    if (i_inv) o_st = i_final ? w_ark_inv : mix(w_ark_inv, 1'b1);
    else       o_st = (i_final ? w_sr : mix(w_sr, 1'b0)) ^ i_rk;
  end
endmodule

// File: rtl/expand128.sv
// AES-128 key expander producing one 128-bit round key per cycle.
//   clk      : clock
//   reset    : synchronous load of key; rk0 on roundKey the next cycle
//   done1    : step backwards (rk[i] -> rk[i-1]) instead of forwards
//   done2    : freeze the current key
//   key      : cipher key
//   roundKey : current round key
module expand128
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         done1,
  input  logic         done2,
  input  logic [127:0] key,
  output logic [127:0] roundKey
);
  logic [127:0] r_rk;
  logic [3:0]   r_idx;  // index of the key currently held
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_sw_in, w_sw, w_t, w_f0;
  logic [127:0] w_fwd, w_rev;

  assign {w_w0, w_w1, w_w2, w_w3} = r_rk;

  // Going backwards, the last word of the previous key is w3^w2, and that is
  // the word fed through RotWord/SubWord; one S-box serves both directions.
  assign w_sw_in = done1 ? (w_w2 ^ w_w3) : w_w3;

  subword u_sub (
    .i_word({w_sw_in[23:0], w_sw_in[31:24]}),
    .o_word(w_sw)
  );

  assign w_t   = w_sw ^ {rcon(done1 ? r_idx : r_idx + 4'd1), 24'h0};
  assign w_f0  = w_w0 ^ w_t;
  assign w_fwd = {w_f0, w_w1 ^ w_f0, w_w2 ^ w_w1 ^ w_f0, w_w3 ^ w_w2 ^ w_w1 ^ w_f0};
  assign w_rev = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};

  // NOTE: no asynchronous reset on these registers; they are always loaded
  // through the synchronous reset input before their contents are used.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rk  <= key;
      r_idx <= '0;
    end else if (!done2) begin
      r_rk  <= done1 ? w_rev : w_fwd;
      r_idx <= done1 ? r_idx - 4'd1 : r_idx + 4'd1;
    end
  end

  assign roundKey = r_rk;
endmodule

// File: rtl/invsubword.sv
// Inverse S-box applied to each byte of a 32-bit word.
//   i_word : input word    o_word : substituted word
module invsubword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  assign o_word = {inv_sbox(i_word[31:24]), inv_sbox(i_word[23:16]),
                   inv_sbox(i_word[15:8]),  inv_sbox(i_word[7:0])};
endmodule

// File: rtl/subword.sv
// Forward S-box applied to each byte of a 32-bit word.
//   i_word : input word    o_word : substituted word
module subword
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);
  assign o_word = {sbox(i_word[31:24]), sbox(i_word[23:16]),
                   sbox(i_word[15:8]),  sbox(i_word[7:0])};
endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES-128 cipher / inverse cipher, one round per cycle, driving an
// external expand128 instance.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : start/decrypt/din request, busy/done/dout status
//   i_round_key  : current round key from the expander
//   o_exp_reset  : expander load (high in IDLE)
//   o_exp_done1  : expander reverse direction (decrypt rounds)
//   o_exp_done2  : expander freeze (completion cycle)
// Decrypt first spends KFWD_CYCLES cycles letting the expander run forward to
// rk10, then reverses it so keys arrive rk10..rk0 during the rounds.
module aes_cipher_core
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  aes_cipher_core_if.slave     bus,
  input  logic [127:0]         i_round_key,
  output logic                 o_exp_reset,
  output logic                 o_exp_done1,
  output logic                 o_exp_done2
);
  state_t       r_state, w_next;
  logic [3:0]   r_cnt;
  logic [127:0] r_st, r_dout;
  logic         r_dec;
  logic         w_final;
  logic [127:0] w_round, w_st_next;

  assign w_final = (r_cnt == 4'(NR));

  aes_round u_round (
    .i_st   (r_st),
    .i_rk   (i_round_key),
    .i_inv  (r_dec),
    .i_final(w_final),
    .o_st   (w_round)
  );

  // The first round cycle is the bare AddRoundKey (rk0, or rk10 when decrypting).
  assign w_st_next = (r_cnt == '0) ? (r_st ^ i_round_key) : w_round;

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next      = r_state;
    o_exp_reset = 1'b0;
    o_exp_done1 = 1'b0;
    o_exp_done2 = 1'b0;
    bus.busy    = 1'b1;
    bus.done    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_exp_reset = 1'b1;
        bus.busy    = 1'b0;
        if (bus.start) w_next = bus.decrypt ? S_KFWD : S_ROUND;
      end
      S_KFWD: begin
        if (r_cnt == 4'(KFWD_CYCLES - 1)) w_next = S_ROUND;
      end
      S_ROUND: begin
        o_exp_done1 = r_dec;
        if (w_final) w_next = S_FIN;
      end
      S_FIN: begin
        o_exp_done1 = r_dec;
        o_exp_done2 = 1'b1;
        bus.done    = 1'b1;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_st   <= '0;
      r_dec  <= 1'b0;
      r_dout <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_st  <= bus.din;
            r_dec <= bus.decrypt;
            r_cnt <= '0;
          end
        end
        S_KFWD: r_cnt <= (r_cnt == 4'(KFWD_CYCLES - 1)) ? '0 : r_cnt + 4'd1;
        S_ROUND: begin
          r_st <= w_st_next;
          if (w_final) begin
            r_dout <= w_st_next;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.dout = r_dout;
endmodule

// File: tb/tb_aes_cipher_core.sv
// Self-checking bench for aes_cipher_core + expand128.
// Stimulus pushes expected {dout, completion cycle} into a scoreboard; a
// negedge monitor pops and compares whenever done is high. Expected results
// come from FIPS-197 vectors or a byte-level AES reference model.
module tb_aes_cipher_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key;
  logic [127:0] w_rk;
  logic         exp_reset, exp_done1, exp_done2;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [127:0] last_exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_cipher_core_if u_if ();

  expand128 u_exp (
    .clk(clk), .reset(exp_reset), .done1(exp_done1), .done2(exp_done2),
    .key(key), .roundKey(w_rk)
  );

  aes_cipher_core u_dut (
    .clk(clk), .rst(rst), .bus(u_if), .i_round_key(w_rk),
    .o_exp_reset(exp_reset), .o_exp_done1(exp_done1), .o_exp_done2(exp_done2)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t[256];
  logic [7:0] isbox_t[256];

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Walk the multiplicative group with generator 3 and its inverse.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4) ^ 8'h63;
      sbox_t[p]  = x;
      isbox_t[x] = p;
    end while (p != 8'h01);
    sbox_t[0]     = 8'h63;
    isbox_t[8'h63] = 8'h00;
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 0; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] bget(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] t_sub(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inv ? isbox_t[bget(s, i)] : sbox_t[bget(s, i)];
    return r;
  endfunction

  function automatic logic [127:0] t_shift(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127-8*(row+4*c) -: 8] = bget(s, row + 4 * (inv ? (c + 4 - row) % 4 : (c + row) % 4));
    return r;
  endfunction

  // Circulant matrix: out[r] = sum_j a[j] * m[(j - r) mod 4].
  function automatic logic [127:0] t_mix(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    logic [7:0]   m[4];
    logic [7:0]   acc;
    if (inv) m = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     m = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 0;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(bget(s, 4*c + j), m[(j - row + 4) % 4]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [10:0][127:0] ref_keys(input logic [127:0] k);
    logic [31:0]        w[44];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [10:0][127:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] d, input logic dec);
    logic [10:0][127:0] ks;
    logic [127:0]       s;
    ks = ref_keys(k);
    if (!dec) begin
      s = d ^ ks[0];
      for (int r = 1; r <= 10; r++) begin
        s = t_shift(t_sub(s, 1'b0), 1'b0);
        if (r < 10) s = t_mix(s, 1'b0);
        s = s ^ ks[r];
      end
    end else begin
      s = d ^ ks[10];
      for (int r = 9; r >= 0; r--) begin
        s = t_sub(t_shift(s, 1'b1), 1'b1) ^ ks[r];
        if (r > 0) s = t_mix(s, 1'b1);
      end
    end
    return s;
  endfunction

  // ---------------- scoreboard + monitor ----------------
  typedef struct {
    logic [127:0] dout;
    int           cyc;
  } exp_t;
  exp_t sb[$];
  logic prev_done = 1'b0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (prev_done) check("done_pulse_width", u_if.done, 1'b0);
      if (u_if.done) begin
        if (sb.size() == 0) check("unexpected_done", u_if.done, 1'b0);
        else begin
          e = sb.pop_front();
          check("dout", u_if.dout, e.dout);
          check("done_cycle", cyc, e.cyc);
        end
      end
    end
    prev_done <= u_if.done;
  end

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called right after a negedge; returns at the negedge of the first idle
  // cycle so the next call is issued back-to-back.
  task automatic run_op(input logic [127:0] k, input logic [127:0] d, input logic dec,
                        input logic [127:0] expv, input logic mid_start);
    int t0, lat;
    lat = dec ? 22 : 12;
    key = k; u_if.din = d; u_if.decrypt = dec; u_if.start = 1'b1;
    t0 = cyc;
    sb.push_back('{expv, t0 + lat});
    for (int i = 1; i <= lat + 1; i++) begin
      @(negedge clk);
      u_if.start   = mid_start && (i == 4);
      u_if.din     = rand128();
      u_if.decrypt = 1'($urandom_range(0, 1));
      if (i <= lat) begin
        check("busy_active", u_if.busy, 1'b1);
        check("exp_reset_active", exp_reset, 1'b0);
        check("exp_done1", exp_done1, dec && (i >= 11));
        check("exp_done2", exp_done2, i == lat);
      end else begin
        check("busy_idle", u_if.busy, 1'b0);
        check("exp_reset_idle", exp_reset, 1'b1);
        check("done_seen", sb.size(), 0);
      end
    end
    sb.delete();
    last_exp = expv;
  endtask

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  initial begin
    logic [127:0] k, d;
    logic         dec;
    rst = 1'b1;
    key = '0;
    u_if.start = 1'b0; u_if.decrypt = 1'b0; u_if.din = '0;
    build_sbox();
    repeat (3) @(negedge clk);
    check("rst_busy", u_if.busy, 1'b0);
    check("rst_done", u_if.done, 1'b0);
    check("rst_dout", u_if.dout, '0);
    check("rst_exp_reset", exp_reset, 1'b1);
    check("rst_exp_done1", exp_done1, 1'b0);
    check("rst_exp_done2", exp_done2, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op(C1_KEY, C1_PT, 1'b0, C1_CT, 1'b0);
    run_op(C1_KEY, C1_CT, 1'b1, C1_PT, 1'b0);
    run_op(B_KEY, B_PT, 1'b0, B_CT, 1'b0);
    run_op(B_KEY, B_CT, 1'b1, B_PT, 1'b0);
    run_op(C1_KEY, C1_PT, 1'b0, C1_CT, 1'b1);

    for (int i = 0; i < 8; i++) begin
      k = rand128();
      d = rand128();
      dec = 1'($urandom_range(0, 1));
      run_op(k, d, dec, ref_aes(k, d, dec), 1'($urandom_range(0, 1)));
    end

    // Result holds while inputs toggle in IDLE.
    for (int i = 0; i < 20; i++) begin
      u_if.din = rand128();
      u_if.decrypt = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("dout_hold", u_if.dout, last_exp);
    end

    // Reset in the middle of a decrypt.
    key = C1_KEY; u_if.din = C1_CT; u_if.decrypt = 1'b1; u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", u_if.busy, 1'b0);
    check("midrst_dout", u_if.dout, '0);
    check("midrst_exp_reset", exp_reset, 1'b1);
    check("midrst_exp_done1", exp_done1, 1'b0);
    check("midrst_done", u_if.done, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    run_op(C1_KEY, C1_PT, 1'b0, C1_CT, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
